// File: rtl/i2s_codec_port_if.sv
// Serial-port and sample-domain signal bundle for the I2S codec port.
// The master modport is the port itself; the slave modport is the
// codec / sample-processing side.
interface i2s_codec_port_if #(
    parameter int SAMPLE_WIDTH = 16
);
    // Sample-domain side
    logic [SAMPLE_WIDTH-1:0] input_left;
    logic [SAMPLE_WIDTH-1:0] input_right;
    logic [SAMPLE_WIDTH-1:0] output_left;
    logic [SAMPLE_WIDTH-1:0] output_right;
    logic                    sample_valid;
    logic                    sample_clock;
    // Codec serial side
    logic                    adc_data;
    logic                    bclk;
    logic                    lrck;
    logic                    dac_data;

    modport master (
        input  input_left,
        input  input_right,
        input  adc_data,
        output bclk,
        output lrck,
        output dac_data,
        output output_left,
        output output_right,
        output sample_valid,
        output sample_clock
    );

    modport slave (
        output input_left,
        output input_right,
        output adc_data,
        input  bclk,
        input  lrck,
        input  dac_data,
        input  output_left,
        input  output_right,
        input  sample_valid,
        input  sample_clock
    );
endinterface

// File: rtl/i2s_codec_port.sv
// Master-mode I2S port for the WM8731: derives BCLK/LRCK from the codec
// master clock, shifts ADC words in, shifts DAC words out (one-BCLK-delayed
// I2S framing, MSB first) and supplies the frame-rate sample_clock.
module i2s_codec_port #(
    parameter int BCLK_HALF    = 3,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_BITS    = 32
) (
    input  logic             audio_clock,
    input  logic             reset,
    i2s_codec_port_if.master bus
);
    localparam int FRAME_BITS   = 2 * SLOT_BITS;
    localparam int CNT_W        = $clog2(FRAME_BITS);
    localparam int DIV_W        = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int TX_LATCH_POS = FRAME_BITS - 4;
    localparam int LEFT_DONE    = SAMPLE_WIDTH;
    localparam int RIGHT_DONE   = SLOT_BITS + SAMPLE_WIDTH;

    logic [DIV_W-1:0]        r_div_cnt;
    logic                    r_bclk;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic                    r_lrck;
    logic                    r_sample_clock;
    logic                    r_dac_data;
    logic [SAMPLE_WIDTH-1:0] r_tx_left;
    logic [SAMPLE_WIDTH-1:0] r_tx_right;
    logic [SAMPLE_WIDTH-1:0] r_rx_shift;
    logic [SAMPLE_WIDTH-1:0] r_rx_left;
    logic [SAMPLE_WIDTH-1:0] r_out_left;
    logic [SAMPLE_WIDTH-1:0] r_out_right;
    logic                    r_sample_valid;

    logic                    w_tick;
    logic                    w_rise;
    logic                    w_fall;
    logic [CNT_W-1:0]        w_bit_cnt_next;
    logic [CNT_W-1:0]        w_next_pos;
    logic [CNT_W-1:0]        w_cur_pos;
    logic                    w_rx_active;
    logic [SAMPLE_WIDTH-1:0] w_tx_word;
    logic [SAMPLE_WIDTH-1:0] w_tx_shift;
    logic                    w_tx_bit;
    logic [SAMPLE_WIDTH-1:0] w_rx_word;

    // Divider terminal count splits into BCLK rise and fall events.
    assign w_tick = (r_div_cnt == DIV_W'(BCLK_HALF - 1));
    assign w_rise = w_tick & ~r_bclk;
    assign w_fall = w_tick &  r_bclk;

    // Next frame position and the DAC bit that belongs to it; slot
    // positions 1..SAMPLE_WIDTH carry the word MSB first, all others are 0.
    always_comb begin
        w_bit_cnt_next = (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) ? '0 : r_bit_cnt + 1'b1;
        w_next_pos     = w_bit_cnt_next % CNT_W'(SLOT_BITS);
        w_cur_pos      = r_bit_cnt % CNT_W'(SLOT_BITS);
        w_tx_word      = (w_bit_cnt_next >= CNT_W'(SLOT_BITS)) ? r_tx_right : r_tx_left;
        w_tx_shift     = '0;
        w_tx_bit       = 1'b0;
        if (w_next_pos >= CNT_W'(1) && w_next_pos <= CNT_W'(SAMPLE_WIDTH)) begin
            w_tx_shift = w_tx_word << (w_next_pos - CNT_W'(1));
            w_tx_bit   = w_tx_shift[SAMPLE_WIDTH-1];
        end
        w_rx_active = (w_cur_pos >= CNT_W'(1)) && (w_cur_pos <= CNT_W'(SAMPLE_WIDTH));
        w_rx_word   = {r_rx_shift[SAMPLE_WIDTH-2:0], bus.adc_data};
    end

    // Clock divider, frame counter, word select, sample clock and DAC shift-out.
    always_ff @(posedge audio_clock or posedge reset) begin
        if (reset) begin
            r_div_cnt      <= '0;
            r_bclk         <= 1'b0;
            r_bit_cnt      <= CNT_W'(FRAME_BITS - 1);
            r_lrck         <= 1'b1;
            r_sample_clock <= 1'b0;
            r_dac_data     <= 1'b0;
            r_tx_left      <= '0;
            r_tx_right     <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
                r_bclk <= ~r_bclk;
            end
            if (w_fall) begin
                r_bit_cnt      <= w_bit_cnt_next;
                r_lrck         <= (w_bit_cnt_next >= CNT_W'(SLOT_BITS));
                r_sample_clock <= (w_bit_cnt_next <  CNT_W'(SLOT_BITS));
                r_dac_data     <= w_tx_bit;
                // Sampled late in the frame so the processing chain, clocked
                // by sample_clock, has long since settled its outputs.
                if (w_bit_cnt_next == CNT_W'(TX_LATCH_POS)) begin
                    r_tx_left  <= bus.input_left;
                    r_tx_right <= bus.input_right;
                end
            end
        end
    end

    // ADC shift-in on BCLK rise; left/right are published together once per frame.
    always_ff @(posedge audio_clock or posedge reset) begin
        if (reset) begin
            r_rx_shift     <= '0;
            r_rx_left      <= '0;
            r_out_left     <= '0;
            r_out_right    <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            if (w_rise && w_rx_active) begin
                r_rx_shift <= w_rx_word;
                if (r_bit_cnt == CNT_W'(LEFT_DONE)) begin
                    r_rx_left <= w_rx_word;
                end
                if (r_bit_cnt == CNT_W'(RIGHT_DONE)) begin
                    r_out_left     <= r_rx_left;
                    r_out_right    <= w_rx_word;
                    r_sample_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.bclk         = r_bclk;
    assign bus.lrck         = r_lrck;
    assign bus.sample_clock = r_sample_clock;
    assign bus.dac_data     = r_dac_data;
    assign bus.output_left  = r_out_left;
    assign bus.output_right = r_out_right;
    assign bus.sample_valid = r_sample_valid;
endmodule
